// File: rtl/nitta_run_ctrl_pkg.sv
// Shared types for the NITTA board run controller.
//   mode_e    : run-controller state, also exported on the mode pins
//   led_sel_e : which debug byte drives the LEDs (code 3 is never produced)
//   led_next  : LED selector rotation used by key0 while running
package nitta_run_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_HALT  = 2'd0,
    MODE_STEP  = 2'd1,
    MODE_RUN   = 2'd2,
    MODE_DRAIN = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    LED_STATUS = 2'd0,
    LED_BUS1   = 2'd1,
    LED_BUS2   = 2'd2
  } led_sel_e;

  function automatic led_sel_e led_next(input led_sel_e cur);
    case (cur)
      LED_STATUS: return LED_BUS1;
      LED_BUS1:   return LED_BUS2;
      default:    return LED_STATUS;
    endcase
  endfunction

endpackage

// File: rtl/nitta_run_ctrl_if.sv
// Board-side signal bundle of the run controller.
//   key_n        : raw active-low push keys (asynchronous)
//   boost_req    : raw dip switch, 1 = request the 200 MHz processor clock
//   net_clk_slow : slow / single-step processor clock
//   boost_sel    : 1 = top level muxes clk_200MHz onto the processor clock
//   led_sel      : debug byte shown on the LEDs
//   mode         : controller state
//   cycle_cnt    : count of net_clk_slow rising edges
// master = board/stimulus side, slave = controller side.
interface nitta_run_ctrl_if #(
  parameter int CNT_W = 16
);
  import nitta_run_ctrl_pkg::*;

  logic [1:0]       key_n;
  logic             boost_req;
  logic             net_clk_slow;
  logic             boost_sel;
  led_sel_e         led_sel;
  mode_e            mode;
  logic [CNT_W-1:0] cycle_cnt;

  modport master (
    output key_n, boost_req,
    input  net_clk_slow, boost_sel, led_sel, mode, cycle_cnt
  );

  modport slave (
    input  key_n, boost_req,
    output net_clk_slow, boost_sel, led_sel, mode, cycle_cnt
  );

endinterface

// File: rtl/nitta_key_debounce.sv
// Push-key conditioner: 2-FF synchroniser, stability counter, debounced
// level and a one-cycle press pulse on the released->pressed transition.
//   clk_5kHz : controller clock
//   rst      : synchronous, active-high; level returns to "released"
//   key_n    : raw active-low key, asynchronous
//   press    : registered one-cycle pulse per accepted press
module nitta_key_debounce #(
  parameter int DEBOUNCE = 50
) (
  input  logic clk_5kHz,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  // Synchroniser carries the pressed sense (1 = pressed) so reset value 0 means released.
  logic [1:0]    sync_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;

  // NOTE: all state here updates with non-blocking assignments so every register
  // samples the pre-edge values of the others; reset is synchronous to clk_5kHz.
  always_ff @(posedge clk_5kHz) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], ~key_n};
      press  <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE - 1)) begin
        // DEBOUNCE-th consecutive opposite sample: accept the new level.
        level_q <= sync_q[1];
        cnt_q   <= '0;
        press   <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/nitta_run_ctrl.sv
// Run controller for the NITTA processor on the FPGA demo board.
// Owns the slow processor clock (HALT / single STEP / continuous RUN with a
// DRAIN that never truncates a high pulse), the glitch-safe boost select,
// the LED debug-byte selector and a rising-edge counter.
//   clk_5kHz : controller clock from the PLL
//   rst      : synchronous, active-high reset
//   bus      : slave side of nitta_run_ctrl_if (keys, dip, all outputs)
// All outputs come straight from registers.
module nitta_run_ctrl #(
  parameter int SLOW_DIV = 5000,
  parameter int DEBOUNCE = 50,
  parameter int CNT_W    = 16
) (
  input logic             clk_5kHz,
  input logic             rst,
  nitta_run_ctrl_if.slave bus
);
  import nitta_run_ctrl_pkg::*;

  localparam int HALF = SLOW_DIV / 2;
  localparam int PW   = $clog2(SLOW_DIV);

  logic             press0;
  logic             press1;
  logic             both;
  logic [1:0]       boost_sync_q;
  mode_e            mode_q;
  led_sel_e         led_q;
  logic [PW-1:0]    phase_q;
  logic             clk_q;
  logic             boost_q;
  logic [CNT_W-1:0] cnt_q;
  logic             phase_last;
  logic             phase_hi;
  logic             halt_now;
  logic             clk_d;

  nitta_key_debounce #(.DEBOUNCE(DEBOUNCE)) u_key0 (
    .clk_5kHz (clk_5kHz),
    .rst      (rst),
    .key_n    (bus.key_n[0]),
    .press    (press0)
  );

  nitta_key_debounce #(.DEBOUNCE(DEBOUNCE)) u_key1 (
    .clk_5kHz (clk_5kHz),
    .rst      (rst),
    .key_n    (bus.key_n[1]),
    .press    (press1)
  );

  assign both       = press0 & press1;
  assign phase_last = (phase_q == PW'(SLOW_DIV - 1));
  assign phase_hi   = (phase_q < PW'(HALF));

  // Stop from RUN while the output is low: hold it low on this edge too, so a
  // phase wrapping to 0 cannot start a pulse that HALT would then leave high.
  assign halt_now = (mode_q == MODE_RUN) && press1 && !press0 && !clk_q;

  // Next value of the slow clock; shared by the output register and the edge counter.
  assign clk_d = (mode_q != MODE_HALT) && !halt_now && phase_hi;

  always_ff @(posedge clk_5kHz) begin
    if (rst) begin
      boost_sync_q <= '0;
      mode_q       <= MODE_HALT;
      led_q        <= LED_STATUS;
      phase_q      <= '0;
      clk_q        <= 1'b0;
      boost_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      boost_sync_q <= {boost_sync_q[0], bus.boost_req};
      clk_q        <= clk_d;

      if (!clk_q && clk_d) begin
        cnt_q <= cnt_q + 1'b1;
      end

      // Switching clock sources is only safe while the slow clock is parked low.
      if (mode_q == MODE_HALT && !clk_q) begin
        boost_q <= boost_sync_q[1];
      end

      if (mode_q != MODE_HALT) begin
        phase_q <= phase_last ? '0 : phase_q + 1'b1;
      end

      if (both) begin
        led_q <= LED_STATUS;
      end

      case (mode_q)
        MODE_HALT: begin
          if (!both) begin
            if (press1) begin
              mode_q  <= MODE_RUN;
              phase_q <= '0;
            end else if (press0) begin
              mode_q  <= MODE_STEP;
              phase_q <= '0;
            end
          end
        end
        MODE_STEP: begin
          if (phase_last) mode_q <= MODE_HALT;
        end
        MODE_RUN: begin
          if (!both) begin
            if (press0) begin
              led_q <= led_next(led_q);
            end else if (press1) begin
              mode_q <= clk_q ? MODE_DRAIN : MODE_HALT;
            end
          end
        end
        MODE_DRAIN: begin
          // Last high tick is emitted on this edge; HALT pulls the output low next.
          if (phase_q == PW'(HALF - 1)) mode_q <= MODE_HALT;
        end
        default: mode_q <= MODE_HALT;
      endcase
    end
  end

  assign bus.net_clk_slow = clk_q;
  assign bus.boost_sel    = boost_q;
  assign bus.led_sel      = led_q;
  assign bus.mode         = mode_q;
  assign bus.cycle_cnt    = cnt_q;

endmodule

// File: tb/tb_nitta_run_ctrl.sv
`timescale 1ns/1ps
module tb_nitta_run_ctrl;
  import nitta_run_ctrl_pkg::*;

  localparam int SLOW_DIV = 10;
  localparam int DEBOUNCE = 4;
  localparam int CNT_W    = 4;   // narrow counter so the all-ones wrap is reachable quickly

  typedef struct {
    logic             clk;
    mode_e            mode;
    logic             chk_cnt;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sb[$];
  int               n_cmp = 0;
  int               n_bad = 0;
  logic             clk_5kHz = 1'b0;
  logic             rst = 1'b1;
  logic [CNT_W-1:0] exp_cnt = '0;

  nitta_run_ctrl_if #(.CNT_W(CNT_W)) bus ();

  nitta_run_ctrl #(
    .SLOW_DIV (SLOW_DIV),
    .DEBOUNCE (DEBOUNCE),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_5kHz (clk_5kHz),
    .rst      (rst),
    .bus      (bus.slave)
  );

  always #10 clk_5kHz = ~clk_5kHz;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers (no comparisons inside) ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk_5kHz);
  endtask

  task automatic push_exp(input logic c, input mode_e m, input int n, input logic chk);
    exp_t e;
    e.clk = c; e.mode = m; e.chk_cnt = chk; e.cnt = exp_cnt;
    repeat (n) sb.push_back(e);
  endtask

  task automatic wait_mode(input mode_e m, input int budget, output bit ok, output int ticks);
    ok = 1'b0; ticks = 0;
    while (!ok && ticks < budget) begin
      @(negedge clk_5kHz);
      ticks++;
      if (bus.mode === m) ok = 1'b1;
    end
  endtask

  // Waits for a sample where net_clk_slow has just changed to lvl.
  task automatic wait_clk(input logic lvl, input int budget, output bit ok);
    logic prev;
    int   t;
    prev = bus.net_clk_slow; ok = 1'b0; t = 0;
    while (!ok && t < budget) begin
      @(negedge clk_5kHz);
      t++;
      if (bus.net_clk_slow === lvl && prev !== lvl) ok = 1'b1;
      prev = bus.net_clk_slow;
    end
  endtask

  task automatic wait_led_change(input int budget, output bit ok);
    led_sel_e prev;
    int       t;
    prev = bus.led_sel; ok = 1'b0; t = 0;
    while (!ok && t < budget) begin
      @(negedge clk_5kHz);
      t++;
      if (bus.led_sel !== prev) ok = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1; bus.key_n = 2'b11; bus.boost_req = 1'b0;
    tick(3);
    n_cmp++; if (bus.net_clk_slow !== 1'b0) begin n_bad++; $display("FAIL reset_clk: got %b want 0", bus.net_clk_slow); end
    n_cmp++; if (bus.boost_sel !== 1'b0) begin n_bad++; $display("FAIL reset_boost: got %b want 0", bus.boost_sel); end
    n_cmp++; if (bus.led_sel !== LED_STATUS) begin n_bad++; $display("FAIL reset_led: got %0d want 0", bus.led_sel); end
    n_cmp++; if (bus.mode !== MODE_HALT) begin n_bad++; $display("FAIL reset_mode: got %0d want 0", bus.mode); end
    n_cmp++; if (bus.cycle_cnt !== '0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", bus.cycle_cnt); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_debounce;
    bit ok;
    int t;
    bus.key_n[0] = 1'b0; tick(3); bus.key_n[0] = 1'b1; tick(12);
    n_cmp++; if (bus.mode !== MODE_HALT) begin n_bad++; $display("FAIL glitch_ignored: mode %0d want 0", bus.mode); end
    bus.key_n[0] = 1'b0;
    wait_mode(MODE_STEP, 12, ok, t);
    n_cmp++;
    if (!ok || t < DEBOUNCE + 2 || t > DEBOUNCE + 4) begin
      n_bad++; $display("FAIL press_latency: STEP seen=%0d after %0d ticks, want %0d..%0d", ok, t, DEBOUNCE + 2, DEBOUNCE + 4);
    end
    if (t < 10) tick(10 - t);
    bus.key_n[0] = 1'b1;
    wait_mode(MODE_HALT, 20, ok, t);
    tick(15);
    exp_cnt = 1;
    n_cmp++;
    if (!ok || bus.mode !== MODE_HALT || bus.cycle_cnt !== exp_cnt) begin
      n_bad++; $display("FAIL single_press: mode %0d cnt %0d, want mode 0 cnt %0d", bus.mode, bus.cycle_cnt, exp_cnt);
    end
  endtask

  task automatic test_step;
    bit   ok;
    int   t;
    exp_t e;
    bus.key_n[0] = 1'b0;
    wait_mode(MODE_STEP, 12, ok, t);
    bus.key_n[0] = 1'b1;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL step_entry: mode %0d want 1", bus.mode); end
    exp_cnt++;
    push_exp(1'b1, MODE_STEP, 5, 1'b1);
    push_exp(1'b0, MODE_STEP, 4, 1'b1);
    push_exp(1'b0, MODE_HALT, 3, 1'b1);
    for (int i = 1; sb.size() > 0; i++) begin
      @(negedge clk_5kHz);
      e = sb.pop_front();
      n_cmp++;
      if (bus.net_clk_slow !== e.clk || bus.mode !== e.mode || (e.chk_cnt && bus.cycle_cnt !== e.cnt)) begin
        n_bad++;
        $display("FAIL step s%0d: clk/mode/cnt %b/%0d/%0d want %b/%0d/%0d",
                 i, bus.net_clk_slow, bus.mode, bus.cycle_cnt, e.clk, e.mode, e.cnt);
      end
      if (i == 1) bus.key_n[1] = 1'b0;   // press lands mid-step and must be ignored
    end
    bus.key_n[1] = 1'b1;
    tick(8);
    n_cmp++; if (bus.mode !== MODE_HALT) begin n_bad++; $display("FAIL step_press_ignored: mode %0d want 0", bus.mode); end
  endtask

  task automatic test_run_and_led;
    bit       ok;
    int       t;
    exp_t     e;
    led_sel_e seq [5] = '{LED_BUS1, LED_BUS2, LED_STATUS, LED_BUS1, LED_BUS2};
    bus.key_n[1] = 1'b0;
    wait_mode(MODE_RUN, 12, ok, t);
    bus.key_n[1] = 1'b1;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL run_entry: mode %0d want 2", bus.mode); end
    push_exp(1'b1, MODE_RUN, 5, 1'b0);
    push_exp(1'b0, MODE_RUN, 5, 1'b0);
    push_exp(1'b1, MODE_RUN, 5, 1'b0);
    push_exp(1'b0, MODE_RUN, 5, 1'b0);
    for (int i = 1; sb.size() > 0; i++) begin
      @(negedge clk_5kHz);
      e = sb.pop_front();
      n_cmp++;
      if (bus.net_clk_slow !== e.clk || bus.mode !== e.mode) begin
        n_bad++;
        $display("FAIL run s%0d: clk/mode %b/%0d want %b/%0d", i, bus.net_clk_slow, bus.mode, e.clk, e.mode);
      end
    end
    for (int j = 0; j < 5; j++) begin
      bus.key_n[0] = 1'b0;
      wait_led_change(12, ok);
      n_cmp++;
      if (!ok || bus.led_sel !== seq[j] || bus.mode !== MODE_RUN) begin
        n_bad++; $display("FAIL led_step%0d: led %0d mode %0d want led %0d mode 2", j, bus.led_sel, bus.mode, seq[j]);
      end
      bus.key_n[0] = 1'b1;
      tick(8);
    end
    bus.key_n = 2'b00;
    wait_led_change(12, ok);
    n_cmp++;
    if (!ok || bus.led_sel !== LED_STATUS || bus.mode !== MODE_RUN) begin
      n_bad++; $display("FAIL both_keys: led %0d mode %0d want led 0 mode 2", bus.led_sel, bus.mode);
    end
    bus.key_n = 2'b11;
    tick(8);
  endtask

  task automatic test_drain;
    bit   ok;
    exp_t e;
    wait_clk(1'b0, 15, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL drain_sync: no falling edge seen, clk %b", bus.net_clk_slow); end
    bus.key_n[1] = 1'b0;   // press acts at the phase-2 edge
    push_exp(1'b0, MODE_RUN,   4, 1'b0);
    push_exp(1'b1, MODE_RUN,   2, 1'b0);
    push_exp(1'b1, MODE_DRAIN, 2, 1'b0);
    push_exp(1'b1, MODE_HALT,  1, 1'b0);
    push_exp(1'b0, MODE_HALT,  2, 1'b0);
    for (int i = 1; sb.size() > 0; i++) begin
      @(negedge clk_5kHz);
      e = sb.pop_front();
      n_cmp++;
      if (bus.net_clk_slow !== e.clk || bus.mode !== e.mode) begin
        n_bad++;
        $display("FAIL drain s%0d: clk/mode %b/%0d want %b/%0d", i, bus.net_clk_slow, bus.mode, e.clk, e.mode);
      end
    end
    bus.key_n[1] = 1'b1;
    tick(8);
  endtask

  task automatic test_halt_immediate;
    bit   ok;
    int   t;
    exp_t e;
    bus.key_n[1] = 1'b0;
    wait_mode(MODE_RUN, 12, ok, t);
    bus.key_n[1] = 1'b1;
    tick(8);
    wait_clk(1'b1, 15, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL halt_sync: no rising edge seen, mode %0d", bus.mode); end
    bus.key_n[1] = 1'b0;   // press acts at the phase-7 edge
    push_exp(1'b1, MODE_RUN,  4, 1'b0);
    push_exp(1'b0, MODE_RUN,  2, 1'b0);
    push_exp(1'b0, MODE_HALT, 2, 1'b0);
    for (int i = 1; sb.size() > 0; i++) begin
      @(negedge clk_5kHz);
      e = sb.pop_front();
      n_cmp++;
      if (bus.net_clk_slow !== e.clk || bus.mode !== e.mode) begin
        n_bad++;
        $display("FAIL halt_now s%0d: clk/mode %b/%0d want %b/%0d", i, bus.net_clk_slow, bus.mode, e.clk, e.mode);
      end
    end
    bus.key_n[1] = 1'b1;
    tick(8);
  endtask

  task automatic test_boost;
    bit ok;
    int t;
    bit seen_high;
    bus.key_n[1] = 1'b0;
    wait_mode(MODE_RUN, 12, ok, t);
    bus.key_n[1] = 1'b1;
    bus.boost_req = 1'b1;
    seen_high = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_5kHz);
      if (bus.boost_sel !== 1'b0) seen_high = 1'b1;
    end
    n_cmp++; if (!ok || seen_high) begin n_bad++; $display("FAIL boost_in_run: boost_sel rose=%b run_ok=%b want rose=0 run_ok=1", seen_high, ok); end
    bus.key_n[1] = 1'b0;
    wait_mode(MODE_HALT, 30, ok, t);
    for (int i = 0; i < 5 && !(bus.mode === MODE_HALT && bus.net_clk_slow === 1'b0); i++) @(negedge clk_5kHz);
    @(negedge clk_5kHz);
    n_cmp++; if (!ok || bus.boost_sel !== 1'b1) begin n_bad++; $display("FAIL boost_apply: boost_sel %b want 1", bus.boost_sel); end
    bus.key_n[1] = 1'b1;
    tick(8);
    bus.key_n[0] = 1'b0;
    wait_mode(MODE_STEP, 12, ok, t);
    bus.key_n[0] = 1'b1;
    bus.boost_req = 1'b0;
    tick(6);
    n_cmp++;
    if (!ok || bus.boost_sel !== 1'b1 || bus.mode !== MODE_STEP) begin
      n_bad++; $display("FAIL boost_hold: boost_sel %b mode %0d want 1 / 1", bus.boost_sel, bus.mode);
    end
    wait_mode(MODE_HALT, 12, ok, t);
    tick(3);
    n_cmp++; if (!ok || bus.boost_sel !== 1'b0) begin n_bad++; $display("FAIL boost_release: boost_sel %b want 0", bus.boost_sel); end
    tick(8);
  endtask

  task automatic test_rst_mid_run;
    bit ok;
    int t;
    bus.key_n[1] = 1'b0;
    wait_mode(MODE_RUN, 12, ok, t);
    bus.key_n[1] = 1'b1;
    tick(8);
    bus.key_n[0] = 1'b0;
    wait_led_change(12, ok);
    bus.key_n[0] = 1'b1;
    n_cmp++; if (!ok || bus.led_sel !== LED_BUS1) begin n_bad++; $display("FAIL rst_pre_led: led %0d want 1", bus.led_sel); end
    wait_clk(1'b1, 15, ok);
    tick(1);
    n_cmp++; if (!ok || bus.net_clk_slow !== 1'b1) begin n_bad++; $display("FAIL rst_pre_high: clk %b want 1", bus.net_clk_slow); end
    rst = 1'b1;
    @(negedge clk_5kHz);
    n_cmp++;
    if (bus.net_clk_slow !== 1'b0 || bus.boost_sel !== 1'b0 || bus.led_sel !== LED_STATUS ||
        bus.mode !== MODE_HALT || bus.cycle_cnt !== '0) begin
      n_bad++;
      $display("FAIL rst_mid: clk %b boost %b led %0d mode %0d cnt %0d want all 0",
               bus.net_clk_slow, bus.boost_sel, bus.led_sel, bus.mode, bus.cycle_cnt);
    end
    rst = 1'b0;
    tick(3);
  endtask

  task automatic test_cnt_wrap;
    bit ok0, ok1;
    int t;
    rst = 1'b1; tick(2); rst = 1'b0; tick(2);
    for (int i = 1; i <= 16; i++) begin
      bus.key_n[0] = 1'b0;
      wait_mode(MODE_STEP, 12, ok0, t);
      bus.key_n[0] = 1'b1;
      wait_mode(MODE_HALT, 15, ok1, t);
      tick(8);
      n_cmp++;
      if (!ok0 || !ok1 || bus.cycle_cnt !== CNT_W'(i)) begin
        n_bad++; $display("FAIL cnt_step%0d: cnt %0d want %0d (step=%b halt=%b)", i, bus.cycle_cnt, CNT_W'(i), ok0, ok1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_step();
    test_run_and_led();
    test_drain();
    test_halt_immediate();
    test_boost();
    test_rst_mid_run();
    test_cnt_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
